// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with a one-cycle conditional jump resolve
// followed by a fixed-length flush window; every output comes straight from a flop.
module pc_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_stall,
  input  logic                  i_jump_req,
  input  logic [DATA_WIDTH-1:0] i_perand0,
  input  logic [DATA_WIDTH-1:0] i_perand1,
  input  logic [DATA_WIDTH-1:0] i_direct_addr,
  input  logic                  i_fetch_ready,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_fetch_valid,
  output logic                  o_flush,
  output logic                  o_taken,
  output logic                  o_busy
);
  typedef enum logic [1:0] {IDLE, RUN, BRANCH, FLUSH} state_t;
  localparam logic [DATA_WIDTH-1:0] ONE = 1;
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, op0_q, op0_d, op1_q, op1_d, tgt_q, tgt_d;
  logic [3:0] cnt_q, cnt_d;
  logic valid_q, valid_d, flush_q, flush_d, taken_q, taken_d, busy_q, busy_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      op0_q   <= '0;
      op1_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      taken_q <= taken_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (!i_stall && i_jump_req) begin
          state_d = BRANCH;
          op0_d   = i_perand0;
          op1_d   = i_perand1;
          tgt_d   = i_direct_addr;
        end else if (!i_stall && valid_q && i_fetch_ready) begin
          pc_d = pc_q + ONE;
        end
      end
      BRANCH: begin
        state_d = (op0_q == op1_q) ? FLUSH : RUN;
        pc_d    = (op0_q == op1_q) ? tgt_q : pc_q;
        cnt_d   = FLUSH_LAST;
      end
      FLUSH: begin
        state_d = (cnt_q == 4'd0) ? RUN : FLUSH;
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // leaving BRANCH/FLUSH fetches immediately; the IDLE->RUN cycle never does
    valid_d = (state_d == RUN) && ((state_q == RUN) ? !i_stall : (state_q != IDLE));
    flush_d = state_d == FLUSH;
    busy_d  = (state_d == BRANCH) || (state_d == FLUSH);
    taken_d = (state_q == BRANCH) && (state_d == FLUSH);
  end
  assign o_pc          = pc_q;
  assign o_fetch_valid = valid_q;
  assign o_flush       = flush_q;
  assign o_taken       = taken_q;
  assign o_busy        = busy_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenario tasks plus a randomized run against a timeline model
// that derives every output from the cycle a jump was accepted.
module tb_pc_sequencer;
  localparam int FC = 2;
  logic clk = 0, rst_n = 1, stall = 0, jump = 0, ready = 0;
  logic [31:0] op0 = 0, op1 = 0, tgt = 0;
  logic [31:0] pc;
  logic valid, flush, taken, busy;
  logic [3:0] pc2;
  logic valid2, flush2, taken2, busy2;
  int checks = 0, errors = 0;
  int cyc, acc, win_end;
  bit m_taken;
  logic [31:0] m_pc, m_tgt;
  logic e_valid, e_flush, e_taken, e_busy;

  pc_sequencer #(.DATA_WIDTH(32), .RESET_PC(32'd0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_jump_req(jump),
    .i_perand0(op0), .i_perand1(op1), .i_direct_addr(tgt), .i_fetch_ready(ready),
    .o_pc(pc), .o_fetch_valid(valid), .o_flush(flush), .o_taken(taken), .o_busy(busy));

  pc_sequencer #(.DATA_WIDTH(4), .RESET_PC(4'd14), .FLUSH_CYCLES(FC)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_jump_req(jump),
    .i_perand0(op0[3:0]), .i_perand1(op1[3:0]), .i_direct_addr(tgt[3:0]), .i_fetch_ready(ready),
    .o_pc(pc2), .o_fetch_valid(valid2), .o_flush(flush2), .o_taken(taken2), .o_busy(busy2));

  always #5 clk = ~clk;

  task automatic model_reset();
    cyc = 0; acc = -10; win_end = 0; m_taken = 0; m_pc = 0; m_tgt = 0;
    e_valid = 0; e_flush = 0; e_taken = 0; e_busy = 0;
  endtask

  // Cycle numbering: cycle 0 follows reset release. A jump accepted in cycle N
  // occupies N+1 (resolve) and, if taken, N+2..N+1+FC (flush).
  task automatic step();
    int c, d;
    @(posedge clk);
    c = cyc;
    d = c + 1;
    if (c >= 1 && c > win_end) begin
      if (!stall && jump) begin
        acc = c; m_taken = (op0 == op1); m_tgt = tgt;
        win_end = c + 1 + (m_taken ? FC : 0);
      end else if (!stall && e_valid && ready) m_pc = m_pc + 1;
    end
    if (m_taken && d == acc + 2) m_pc = m_tgt;
    e_valid = d >= 2 && d > win_end && (d - 1 == win_end || !stall);
    e_busy  = d > acc && d <= win_end;
    e_flush = e_busy && m_taken && d >= acc + 2;
    e_taken = m_taken && d == acc + 2;
    cyc = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; stall = 0; jump = 0; ready = 1;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic go_to_pc(input logic [31:0] p);
    int n = 0;
    while (!(valid === 1'b1 && pc === p) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL go_to_pc timeout got pc=%h required pc=%h", pc, p);
    end
  endtask

  function automatic string got_s();
    return $sformatf("pc=%h v%b f%b t%b b%b", pc, valid, flush, taken, busy);
  endfunction

  function automatic string exp_s();
    return $sformatf("pc=%h v%b f%b t%b b%b", m_pc, e_valid, e_flush, e_taken, e_busy);
  endfunction

  task automatic test_reset();
    #1 rst_n = 0;
    #1;
    checks++;
    if ({pc, valid, flush, taken, busy} !== {32'd0, 4'b0000}) begin
      errors++; $display("FAIL reset_values got %s required pc=0 all flags 0", got_s());
    end
    @(negedge clk); rst_n = 1; ready = 1; model_reset();
    step();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL first_edge_valid got %b required 0", valid); end
    step();
    checks++;
    if ({valid, pc} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL second_edge_fetch got v%b pc=%h required v1 pc=0", valid, pc);
    end
  endtask

  task automatic test_sequential();
    int k = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      if (valid === 1'b1) begin
        checks++;
        if (pc !== 32'(k)) begin errors++; $display("FAIL seq_pc got %h required %h", pc, k); end
        k++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp4 [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    int k = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid2 === 1'b1 && k < 4) begin
        checks++;
        if ({pc2, flush2, taken2, busy2} !== {exp4[k], 3'b000}) begin
          errors++; $display("FAIL wrap_pc got pc=%h f%b t%b b%b required pc=%h", pc2, flush2, taken2, busy2, exp4[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    go_to_pc(5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({valid, pc} !== {1'b0, 32'd5}) begin errors++; $display("FAIL stall_hold got v%b pc=%h required v0 pc=5", valid, pc); end
    end
    stall = 0;
    step();
    checks++;
    if ({valid, pc} !== {1'b1, 32'd5}) begin errors++; $display("FAIL unstall got v%b pc=%h required v1 pc=5", valid, pc); end
    ready = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({valid, pc} !== {1'b1, 32'd5}) begin errors++; $display("FAIL not_ready_hold got v%b pc=%h required v1 pc=5", valid, pc); end
    end
    ready = 1;
    step();
    checks++;
    if (pc !== 32'd6) begin errors++; $display("FAIL ready_advance got pc=%h required 6", pc); end
  endtask

  task automatic test_taken();
    do_reset();
    go_to_pc(8);
    op0 = 32'h12; op1 = 32'h12; tgt = 32'h40; jump = 1;
    step();
    jump = 0;
    checks++;
    if ({pc, valid, flush, taken, busy} !== {32'h8, 4'b0001}) begin errors++; $display("FAIL taken_branch got %s required pc=8 v0 f0 t0 b1", got_s()); end
    step();
    checks++;
    if ({pc, valid, flush, taken, busy} !== {32'h40, 4'b0111}) begin errors++; $display("FAIL taken_pulse got %s required pc=40 v0 f1 t1 b1", got_s()); end
    step();
    checks++;
    if ({pc, valid, flush, taken, busy} !== {32'h40, 4'b0101}) begin errors++; $display("FAIL taken_flush2 got %s required pc=40 v0 f1 t0 b1", got_s()); end
    step();
    checks++;
    if ({pc, valid, flush, taken, busy} !== {32'h40, 4'b1000}) begin errors++; $display("FAIL taken_resume got %s required pc=40 v1 f0 t0 b0", got_s()); end
    step();
    checks++;
    if ({pc, valid} !== {32'h41, 1'b1}) begin errors++; $display("FAIL taken_next got %s required pc=41 v1", got_s()); end
  endtask

  task automatic test_not_taken();
    do_reset();
    go_to_pc(8);
    op0 = 32'h12; op1 = 32'h13; tgt = 32'h40; jump = 1;
    step();
    jump = 0;
    checks++;
    if ({pc, valid, flush, taken, busy} !== {32'h8, 4'b0001}) begin errors++; $display("FAIL nt_branch got %s required pc=8 v0 f0 t0 b1", got_s()); end
    step();
    checks++;
    if ({pc, valid, flush, taken, busy} !== {32'h8, 4'b1000}) begin errors++; $display("FAIL nt_resume got %s required pc=8 v1 f0 t0 b0", got_s()); end
    step();
    checks++;
    if ({pc, flush, taken} !== {32'h9, 2'b00}) begin errors++; $display("FAIL nt_next got %s required pc=9 f0 t0", got_s()); end
  endtask

  task automatic test_jump_during_stall();
    do_reset();
    go_to_pc(3);
    stall = 1; jump = 1; op0 = 32'h7; op1 = 32'h7; tgt = 32'h20;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({pc, valid, busy} !== {32'h3, 2'b00}) begin errors++; $display("FAIL stalled_jump got %s required pc=3 v0 b0", got_s()); end
    end
    stall = 0;
    step();
    jump = 0;
    checks++;
    if ({pc, valid, busy} !== {32'h3, 2'b01}) begin errors++; $display("FAIL sj_accept got %s required pc=3 v0 b1", got_s()); end
    step();
    checks++;
    if ({pc, flush, taken} !== {32'h20, 2'b11}) begin errors++; $display("FAIL sj_taken got %s required pc=20 f1 t1", got_s()); end
    step();
    step();
    checks++;
    if ({pc, valid, flush, busy} !== {32'h20, 3'b100}) begin errors++; $display("FAIL sj_resume got %s required pc=20 v1 f0 b0", got_s()); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    go_to_pc(4);
    op0 = 32'h5; op1 = 32'h5; tgt = 32'h30; jump = 1;
    step();
    jump = 0;
    step();
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL mf_in_flush got f%b required f1", flush); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({pc, valid, flush, taken, busy} !== {32'd0, 4'b0000}) begin errors++; $display("FAIL mf_async_reset got %s required pc=0 all flags 0", got_s()); end
    @(negedge clk); rst_n = 1; model_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({flush, taken} !== 2'b00 || {pc, valid, flush, taken, busy} !== {m_pc, e_valid, e_flush, e_taken, e_busy}) begin
        errors++; $display("FAIL mf_after_release got %s required %s", got_s(), exp_s());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      jump  = ($urandom_range(0, 5) == 0);
      ready = ($urandom_range(0, 3) != 0);
      op0   = $urandom_range(0, 3);
      op1   = $urandom_range(0, 1) ? op0 : 32'($urandom_range(0, 3));
      tgt   = $urandom;
      step();
      checks++;
      if ({pc, valid, flush, taken, busy} !== {m_pc, e_valid, e_flush, e_taken, e_busy}) begin
        errors++; $display("FAIL random cyc %0d got %s required %s", cyc, got_s(), exp_s());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_wrap();
    test_stall();
    test_taken();
    test_not_taken();
    test_jump_during_stall();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
